// File: rtl/run_ctrl_pkg.sv
// Shared types and default parameters for the run sequencer.
// The optional watchdog is enabled by defining RUN_CTRL_WATCHDOG_EN.
package run_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ARMED,
      CLEAR,
      RUN,
      DONE
   } run_state_t;

   localparam int CYCLE_W_DEF      = 16;
   localparam int MAX_CYCLES_DEF   = 4096;
   localparam int CLEAR_CYCLES_DEF = 2;

   function automatic logic is_busy(input run_state_t s);
      return (s == CLEAR) || (s == RUN);
   endfunction

endpackage

// File: rtl/run_cycle_counter.sv
// Clear/enable counter that saturates at all-ones instead of wrapping.
module run_cycle_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         clear,
   input  logic         enable,
   output logic [W-1:0] count
);

   // NOTE: sequential state is always updated with non-blocking assignments.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/run_controller.sv
// Run sequencer: start/ack handshake, soft-clear pulse, run gating and optional
// cycle-budget watchdog (enabled by defining RUN_CTRL_WATCHDOG_EN).
module run_controller
   import run_ctrl_pkg::*;
#(
   parameter int CYCLE_W      = CYCLE_W_DEF,
   parameter int MAX_CYCLES   = MAX_CYCLES_DEF,
   parameter int CLEAR_CYCLES = CLEAR_CYCLES_DEF
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic               done_in,
   output logic               run_en,
   output logic               soft_clear,
   output logic               ack,
   output logic               timeout,
   output logic               busy,
   output logic [CYCLE_W-1:0] cycle_count
);

   localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
   localparam logic [CLR_W-1:0] CLR_LOAD = CLR_W'(CLEAR_CYCLES - 1);

   run_state_t       state, state_next;
   logic [CLR_W-1:0] clr_cnt, clr_cnt_next;
   logic             wd_hit;
   logic             cnt_clear;

`ifdef RUN_CTRL_WATCHDOG_EN
   assign wd_hit = (cycle_count == CYCLE_W'(MAX_CYCLES - 1));
`else
   assign wd_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         clr_cnt <= '0;
      end else begin
         state   <= state_next;
         clr_cnt <= clr_cnt_next;
      end
   end

   // NOTE: every comb output gets its default first so no latch is inferred.
   always_comb begin
      state_next   = state;
      clr_cnt_next = clr_cnt;
      case (state)
         IDLE:  if (start) state_next = ARMED;
         ARMED: if (!start) begin
                   state_next   = CLEAR;
                   clr_cnt_next = CLR_LOAD;
                end
         CLEAR: if (clr_cnt == '0) state_next = RUN;
                else               clr_cnt_next = clr_cnt - 1'b1;
         RUN:   if (done_in || wd_hit) state_next = DONE;
         DONE:  if (start) state_next = ARMED;
         default: state_next = IDLE;
      endcase
   end

   // Count restarts on the edge that enters CLEAR, so it reads 0 throughout CLEAR.
   assign cnt_clear = (state == ARMED) && !start;

   run_cycle_counter #(.W(CYCLE_W)) u_cycle_counter (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (cnt_clear),
      .enable  (state == RUN),
      .count   (cycle_count)
   );

`ifdef RUN_CTRL_WATCHDOG_EN
   logic timeout_q;

   // done_in has priority over budget exhaustion on the same edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         timeout_q <= 1'b0;
      end else if ((state == RUN) && (done_in || wd_hit)) begin
         timeout_q <= !done_in;
      end else if ((state == DONE) && start) begin
         timeout_q <= 1'b0;
      end
   end

   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif

   assign run_en     = (state == RUN);
   assign soft_clear = (state == CLEAR);
   assign ack        = (state == DONE);
   assign busy       = is_busy(state);

endmodule

// File: tb/tb_run_controller.sv
// Directed self-checking bench for run_controller (main DUT MAX_CYCLES=16, plus a
// 4-bit-counter instance that exercises saturation / early watchdog).
module tb_run_controller;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic        done_in;

   logic        run_en, soft_clear, ack, timeout, busy;
   logic [15:0] cycle_count;

   logic        w_run_en, w_soft_clear, w_ack, w_timeout, w_busy;
   logic [3:0]  w_cycle_count;

   int vectors     = 0;
   int miscompares = 0;

   run_controller #(.CYCLE_W(16), .MAX_CYCLES(16), .CLEAR_CYCLES(2)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .done_in     (done_in),
      .run_en      (run_en),
      .soft_clear  (soft_clear),
      .ack         (ack),
      .timeout     (timeout),
      .busy        (busy),
      .cycle_count (cycle_count)
   );

   run_controller #(.CYCLE_W(4), .MAX_CYCLES(15), .CLEAR_CYCLES(2)) dut_w4 (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .done_in     (done_in),
      .run_en      (w_run_en),
      .soft_clear  (w_soft_clear),
      .ack         (w_ack),
      .timeout     (w_timeout),
      .busy        (w_busy),
      .cycle_count (w_cycle_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic re, input logic sc, input logic ak,
                             input logic to, input logic bz, input logic [31:0] cc);
      check({tag, ".run_en"},      {31'd0, run_en},      {31'd0, re});
      check({tag, ".soft_clear"},  {31'd0, soft_clear},  {31'd0, sc});
      check({tag, ".ack"},         {31'd0, ack},         {31'd0, ak});
      check({tag, ".timeout"},     {31'd0, timeout},     {31'd0, to});
      check({tag, ".busy"},        {31'd0, busy},        {31'd0, bz});
      check({tag, ".cycle_count"}, {16'd0, cycle_count}, cc);
   endtask

   initial begin
      reset_n = 1'b0;
      start   = 1'b1;
      done_in = 1'b0;

      // 1. Reset with start held high, then release and launch a run
      #3;
      check_outs("reset_async", 0, 0, 0, 0, 0, 0);
      tick();
      tick();
      check_outs("reset_held", 0, 0, 0, 0, 0, 0);
      #2 reset_n = 1'b1;
      tick();
      check_outs("armed", 0, 0, 0, 0, 0, 0);
      tick();
      tick();
      start = 1'b0;
      tick();
      check_outs("clear_1", 0, 1, 0, 0, 1, 0);
      tick();
      check_outs("clear_2", 0, 1, 0, 0, 1, 0);
      tick();
      check_outs("run_1", 1, 0, 0, 0, 1, 0);

      // 2. Nominal run, done_in on the 10th RUN cycle
      repeat (8) tick();
      check_outs("run_9", 1, 0, 0, 0, 1, 8);
      tick();
      done_in = 1'b1;
      tick();
      done_in = 1'b0;
      check_outs("done_nominal", 0, 0, 1, 0, 0, 10);
      check("w4.cycle_count_10", {28'd0, w_cycle_count}, 32'd10);
      check("w4.ack_10", {31'd0, w_ack}, 32'd1);
      for (int i = 0; i < 50; i++) begin
         tick();
         check("ack_hold", {31'd0, ack}, 32'd1);
      end
      check("count_kept", {16'd0, cycle_count}, 32'd10);

      // 5. Restart from DONE: ack drops, count kept until CLEAR, then new run
      start = 1'b1;
      tick();
      check_outs("restart_armed", 0, 0, 0, 0, 0, 10);
      tick();
      start = 1'b0;
      tick();
      check_outs("restart_clear", 0, 1, 0, 0, 1, 0);
      tick();
      tick();
      check_outs("restart_run_1", 1, 0, 0, 0, 1, 0);

      // 3. No done_in: watchdog (if built in) fires after 16 RUN cycles
      repeat (15) tick();
      check_outs("run_16", 1, 0, 0, 0, 1, 15);
      check("w4.cycle_count_sat", {28'd0, w_cycle_count}, 32'd15);
`ifdef RUN_CTRL_WATCHDOG_EN
      check("w4.ack_wd", {31'd0, w_ack}, 32'd1);
      check("w4.timeout_wd", {31'd0, w_timeout}, 32'd1);
      tick();
      check_outs("wd_expire", 0, 0, 1, 1, 0, 16);
      repeat (5) tick();
      check_outs("wd_hold", 0, 0, 1, 1, 0, 16);
`else
      check("w4.run_en_nowd", {31'd0, w_run_en}, 32'd1);
      tick();
      check_outs("nowd_run_17", 1, 0, 0, 0, 1, 16);
      repeat (84) tick();
      check_outs("nowd_run_101", 1, 0, 0, 0, 1, 100);
      check("w4.cycle_count_sat_100", {28'd0, w_cycle_count}, 32'd15);
      check("w4.run_en_100", {31'd0, w_run_en}, 32'd1);
      done_in = 1'b1;
      tick();
      done_in = 1'b0;
      check_outs("nowd_done", 0, 0, 1, 0, 0, 101);
      check("w4.ack_nowd", {31'd0, w_ack}, 32'd1);
`endif

      // 4. done_in on the budget-terminal cycle: done wins
      start = 1'b1;
      tick();
      check_outs("t4_armed", 0, 0, 0, 0, 0, 101 - 85 * `ifdef RUN_CTRL_WATCHDOG_EN 1 `else 0 `endif);
      start = 1'b0;
      tick();
      tick();
      tick();
      check_outs("t4_run_1", 1, 0, 0, 0, 1, 0);
      repeat (15) tick();
      done_in = 1'b1;
      tick();
      done_in = 1'b0;
      check_outs("t4_done_wins", 0, 0, 1, 0, 0, 16);

      // 6. Asynchronous reset mid-run, then start=0 alone must not launch
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      repeat (4) tick();
      check_outs("t6_run_5", 1, 0, 0, 0, 1, 4);
      #2 reset_n = 1'b0;
      #1;
      check_outs("t6_async_reset", 0, 0, 0, 0, 0, 0);
      check("w4.busy_reset", {31'd0, w_busy}, 32'd0);
      check("w4.cycle_count_reset", {28'd0, w_cycle_count}, 32'd0);
      tick();
      tick();
      reset_n = 1'b1;
      repeat (5) tick();
      check_outs("t6_idle_after", 0, 0, 0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
